// File: rtl/rx_unit.sv
// UART receiver: 2-flop synchroniser, 16x oversampling tick divider and a frame FSM
// decoding start, 7/8 data bits LSB-first, optional odd/even parity and 1/2 stop bits.
module rx_unit #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       data_length,
    input  logic       stop_bits,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);
    localparam logic [15:0] DIV_2400  = 16'(CLK_FREQ / (OVERSAMPLE * 2400));
    localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (OVERSAMPLE * 4800));
    localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (OVERSAMPLE * 9600));
    localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (OVERSAMPLE * 19200));

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, rx_s;
    logic [15:0] div_cnt_q, div_cnt_d, div_sel;
    logic [1:0]  baud_prev_q, baud_eff;
    logic        tick;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_bit_q, par_bit_d;
    logic        serr_acc_q, serr_acc_d;
    logic [1:0]  baud_q, baud_d, par_q, par_d;
    logic        len_q, len_d, stop2_q, stop2_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        rx_active_q, rx_active_d, rx_done_q, rx_done_d;
    logic        perr_q, perr_d, serr_q, serr_d;
    logic [7:0]  data_byte;
    logic        par_en, perr_calc, stop_sample_err;

    assign rx_s = sync2_q;

    // The divider follows the live baud input only while idle; mid-frame it uses the latched rate.
    always_comb begin
        baud_eff = (state_q == IDLE) ? baud_rate : baud_q;
        unique case (baud_eff)
            2'b00:   div_sel = DIV_2400;
            2'b01:   div_sel = DIV_4800;
            2'b10:   div_sel = DIV_9600;
            default: div_sel = DIV_19200;
        endcase
        tick      = (baud_eff == baud_prev_q) && (div_cnt_q == div_sel - 16'd1);
        div_cnt_d = ((baud_eff != baud_prev_q) || tick) ? 16'd0 : div_cnt_q + 16'd1;
    end

    always_comb begin
        data_byte       = len_q ? shreg_q : {1'b0, shreg_q[7:1]};
        par_en          = (par_q == 2'b01) || (par_q == 2'b10);
        perr_calc       = par_en && ((^data_byte ^ par_bit_q) != (par_q == 2'b01));
        stop_sample_err = serr_acc_q | ~rx_s;
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        serr_acc_d  = serr_acc_q;
        baud_d      = baud_q;
        par_d       = par_q;
        len_d       = len_q;
        stop2_d     = stop2_q;
        data_out_d  = data_out_q;
        rx_active_d = rx_active_q;
        rx_done_d   = 1'b0;
        perr_d      = perr_q;
        serr_d      = serr_q;

        if (tick && (state_q == DATA || state_q == PARITY || state_q == STOP))
            tick_cnt_d = tick_cnt_q + 4'd1;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d     = START;
                    tick_cnt_d  = 4'd0;
                    bit_cnt_d   = 3'd0;
                    serr_acc_d  = 1'b0;
                    rx_active_d = 1'b1;
                    baud_d      = baud_rate;
                    par_d       = parity_type;
                    len_d       = data_length;
                    stop2_d     = stop_bits;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        if (rx_s) begin
                            state_d     = IDLE;
                            rx_active_d = 1'b0;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == (len_q ? 3'd7 : 3'd6)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    par_bit_d = rx_s;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    if (stop2_q && bit_cnt_q == 3'd0) begin
                        bit_cnt_d  = 3'd1;
                        serr_acc_d = stop_sample_err;
                    end else begin
                        // Results are registered together with rx_done so they are valid during the pulse.
                        state_d     = DONE;
                        data_out_d  = data_byte;
                        perr_d      = perr_calc;
                        serr_d      = stop_sample_err;
                        rx_done_d   = 1'b1;
                        rx_active_d = 1'b0;
                    end
                end
            end
            DONE:      state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            div_cnt_q   <= 16'd0;
            baud_prev_q <= 2'b00;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            par_bit_q   <= 1'b0;
            serr_acc_q  <= 1'b0;
            baud_q      <= 2'b00;
            par_q       <= 2'b00;
            len_q       <= 1'b0;
            stop2_q     <= 1'b0;
            data_out_q  <= 8'd0;
            rx_active_q <= 1'b0;
            rx_done_q   <= 1'b0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
        end else begin
            sync1_q     <= rx_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            baud_prev_q <= baud_eff;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            serr_acc_q  <= serr_acc_d;
            baud_q      <= baud_d;
            par_q       <= par_d;
            len_q       <= len_d;
            stop2_q     <= stop2_d;
            data_out_q  <= data_out_d;
            rx_active_q <= rx_active_d;
            rx_done_q   <= rx_done_d;
            perr_q      <= perr_d;
            serr_q      <= serr_d;
        end
    end

    assign data_out     = data_out_q;
    assign rx_active    = rx_active_q;
    assign rx_done      = rx_done_q;
    assign parity_error = perr_q;
    assign stop_error   = serr_q;
endmodule

// File: tb/tb_rx_unit.sv
// Scoreboard bench for rx_unit: frames are serialised from a byte-level model, expected
// results are queued at send time and a monitor checks each rx_done pulse against them.
module tb_rx_unit;
    localparam int CLK_FREQ = 1_228_800;   // gives dividers 32/16/8/4

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] p_baud = 2'b10, p_par = 2'b00;
    logic       p_len = 1'b1, p_stop2 = 1'b0;
    logic [7:0] data_out;
    logic       rx_active, rx_done, parity_error, stop_error;

    rx_unit #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
        .clock(clk), .rst(rst), .rx_in(rx_in),
        .baud_rate(p_baud), .parity_type(p_par), .data_length(p_len), .stop_bits(p_stop2),
        .data_out(data_out), .rx_active(rx_active), .rx_done(rx_done),
        .parity_error(parity_error), .stop_error(stop_error)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic perr; logic serr; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_err = 0;
    int active_cycles = 0, done_count = 0;
    logic [1:0] cfg_baud = 2'b10, cfg_par = 2'b00;
    logic       cfg_len = 1'b1, cfg_stop2 = 1'b0;
    logic [7:0] last_data = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: one line per received frame.
    always @(negedge clk) begin
        if (rx_active) active_cycles++;
        if (rst && rx_done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_rx_done", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                $display("rx frame: data=0x%02h perr=%0b serr=%0b", data_out, parity_error, stop_error);
                check("data_out", 32'(data_out), 32'(e.data));
                check("parity_error", 32'(parity_error), 32'(e.perr));
                check("stop_error", 32'(stop_error), 32'(e.serr));
            end
        end
    end

    function automatic int bit_clks(input logic [1:0] b);
        return (CLK_FREQ / (16 * (2400 << b))) * 16;
    endfunction

    task automatic drive(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bits(input int nbits);
        drive(1'b1, nbits * bit_clks(cfg_baud));
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic [1:0] p, input logic l, input logic s);
        cfg_baud = b; cfg_par = p; cfg_len = l; cfg_stop2 = s;
        p_baud = b; p_par = p; p_len = l; p_stop2 = s;
        idle_bits(2);
    endtask

    // Serialise one frame; expectation comes from the byte, config and deliberate corruptions.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input logic scramble);
        int n, nb, ones;
        logic [7:0] data;
        logic par_en, pbit;
        exp_t e;
        n      = bit_clks(cfg_baud);
        nb     = cfg_len ? 8 : 7;
        data   = cfg_len ? b : {1'b0, b[6:0]};
        par_en = (cfg_par == 2'b01) || (cfg_par == 2'b10);
        ones   = $countones(data);
        pbit   = ((cfg_par == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ bad_par;
        e.data = data;
        e.perr = par_en && ((cfg_par == 2'b01) ? ((ones + int'(pbit)) % 2 == 0)
                                               : ((ones + int'(pbit)) % 2 == 1));
        e.serr = bad_stop;
        exp_q.push_back(e);
        last_data = data;
        drive(1'b0, n);
        if (scramble) begin
            p_baud = 2'($urandom); p_par = 2'($urandom);
            p_len = 1'($urandom); p_stop2 = 1'($urandom);
        end
        for (int i = 0; i < nb; i++) drive(b[i], n);
        if (par_en) drive(pbit, n);
        drive(!(bad_stop && !cfg_stop2), n);
        if (cfg_stop2) drive(!bad_stop, n);
        p_baud = cfg_baud; p_par = cfg_par; p_len = cfg_len; p_stop2 = cfg_stop2;
    endtask

    initial begin
        int a0, d0;
        logic bs;
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_flags", {28'd0, rx_active, rx_done, parity_error, stop_error}, 32'd0);
        rst = 1'b1;

        // 8N1 @9600, 0xA5
        set_cfg(2'b10, 2'b00, 1'b1, 1'b0);
        a0 = active_cycles;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        check("t1_active_len_ok", 32'((active_cycles - a0 >= 9 * 128) && (active_cycles - a0 <= 10 * 128)), 32'd1);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // 7E2 @19200, 0x53 with good then bad parity
        set_cfg(2'b11, 2'b10, 1'b0, 1'b1);
        send_frame(8'h53, 1'b0, 1'b0, 1'b0);
        send_frame(8'h53, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        check("t2_pending", 32'(exp_q.size()), 32'd0);

        // 8O1: 0xFF good parity, then 0x00 with a zero stop bit and a stuck-low line
        set_cfg(2'b10, 2'b01, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        d0 = done_count;
        drive(1'b0, 3 * bit_clks(cfg_baud));
        check("t3_no_active_while_low", 32'(rx_active), 32'd0);
        check("t3_no_extra_done", 32'(done_count - d0), 32'd0);
        idle_bits(2);
        check("t3_pending", 32'(exp_q.size()), 32'd0);

        // Low glitch of 4 ticks
        a0 = active_cycles; d0 = done_count;
        drive(1'b0, 4 * (bit_clks(cfg_baud) / 16));
        idle_bits(2);
        check("t4_active_pulsed", 32'(active_cycles > a0), 32'd1);
        check("t4_active_low", 32'(rx_active), 32'd0);
        check("t4_no_done", 32'(done_count - d0), 32'd0);
        check("t4_data_held", 32'(data_out), 32'(last_data));

        // Three back-to-back 8N1 frames
        set_cfg(2'b10, 2'b00, 1'b1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        check("t5_pending", 32'(exp_q.size()), 32'd0);

        // Reset mid data bits, then a clean 0x5A
        drive(1'b0, bit_clks(cfg_baud));
        for (int i = 0; i < 4; i++) drive(i[0], bit_clks(cfg_baud));
        rst = 1'b0;
        #1;
        check("t6_rst_data_out", 32'(data_out), 32'd0);
        check("t6_rst_flags", {28'd0, rx_active, rx_done, parity_error, stop_error}, 32'd0);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle_bits(2);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        check("t6_pending", 32'(exp_q.size()), 32'd0);

        // Randomised frames, configs and mid-frame config churn
        for (int k = 0; k < 12; k++) begin
            set_cfg(2'($urandom_range(1, 3)), 2'($urandom), 1'($urandom), 1'($urandom));
            bs = ($urandom_range(0, 3) == 0);
            send_frame(8'($urandom), ($urandom_range(0, 2) == 0), bs, 1'($urandom));
            if (bs) drive(1'b0, bit_clks(cfg_baud));
            idle_bits(1);
        end
        idle_bits(1);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
